// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: bundles the sequencer's front-end, arithmetic-unit and
// result-handshake signals.
//   slave  - used by calc_sequencer (receives strobes/au_result, drives unit
//            operands, result and status).
//   master - used by the surrounding environment (input decoder, arithmetic
//            unit, display stage).
// Signals:
//   clr, data_in, load_valid, op_code, op_valid, start   front-end commands
//   au_result                                            unit data_out
//   signal, data_in_a, data_in_b                         unit inputs
//   result, result_valid, result_ack                     output handshake
//   busy, error                                          status
interface calc_sequencer_if;
    logic        clr;
    logic [7:0]  data_in;
    logic        load_valid;
    logic [1:0]  op_code;
    logic        op_valid;
    logic        start;
    logic [15:0] au_result;
    logic [1:0]  signal;
    logic [7:0]  data_in_a;
    logic [7:0]  data_in_b;
    logic [15:0] result;
    logic        result_valid;
    logic        result_ack;
    logic        busy;
    logic        error;

    modport slave (
        input  clr, data_in, load_valid, op_code, op_valid, start, au_result, result_ack,
        output signal, data_in_a, data_in_b, result, result_valid, busy, error
    );

    modport master (
        output clr, data_in, load_valid, op_code, op_valid, start, au_result, result_ack,
        input  signal, data_in_a, data_in_b, result, result_valid, busy, error
    );
endinterface

// File: rtl/calc_sequencer.sv
// calc_sequencer: control FSM for the calculator's 8-bit arithmetic unit.
// Collects operand A, an op code and operand B, holds them on the unit's inputs
// for SETTLE_CYCLES cycles, captures the 16-bit result and offers it with a
// valid/ack handshake.
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   bus_io  calc_sequencer_if.slave (front-end strobes, unit I/O, result, status)
// Parameters:
//   SETTLE_CYCLES  cycles the unit inputs are held before capture (1..15)
// Optional feature macro: RESULT_CHAIN_EN
//   When defined, a legal op_valid in DONE acknowledges the result and reuses
//   result[7:0] as operand A for a chained calculation.
module calc_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input logic             clk,
    input logic             rst_n,
    calc_sequencer_if.slave bus_io
);

    typedef enum logic [2:0] {
        StIdle,
        StGotA,
        StGotOp,
        StGotB,
        StExec,
        StDone
    } state_e;

    localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] OpSub      = 2'b10;

    state_e      state_q, state_d;
    logic [7:0]  reg_a_q, reg_a_d;
    logic [7:0]  reg_b_q, reg_b_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        result_valid_q, result_valid_d;
    logic        error_q, error_d;

    logic op_legal;
    assign op_legal = (bus_io.op_code != 2'b00);

    // Strobe priority inside each state: start > op_valid > load_valid.
    // A strobe not meaningful in the current state is not acted on, so a
    // lower-priority strobe that is meaningful still gets through.
    always_comb begin
        state_d        = state_q;
        reg_a_d        = reg_a_q;
        reg_b_d        = reg_b_q;
        op_d           = op_q;
        result_d       = result_q;
        cnt_d          = cnt_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;

        if (bus_io.clr) begin
            // Abort: like reset but the sticky error survives.
            state_d        = StIdle;
            reg_a_d        = '0;
            reg_b_d        = '0;
            op_d           = '0;
            result_d       = '0;
            cnt_d          = '0;
            result_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        error_d = 1'b1;
                    end else if (bus_io.load_valid) begin
                        reg_a_d = bus_io.data_in;
                        error_d = 1'b0;
                        state_d = StGotA;
                    end
                end
                StGotA: begin
                    if (bus_io.start) begin
                        error_d = 1'b1;
                    end else if (bus_io.op_valid) begin
                        if (op_legal) begin
                            op_d    = bus_io.op_code;
                            state_d = StGotOp;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (bus_io.load_valid) begin
                        reg_a_d = bus_io.data_in;
                    end
                end
                StGotOp: begin
                    if (bus_io.start) begin
                        error_d = 1'b1;
                    end else if (bus_io.op_valid) begin
                        if (op_legal) begin
                            op_d = bus_io.op_code;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (bus_io.load_valid) begin
                        reg_b_d = bus_io.data_in;
                        state_d = StGotB;
                    end
                end
                StGotB: begin
                    if (bus_io.start) begin
                        cnt_d   = SettleInit;
                        state_d = StExec;
                    end else if (bus_io.op_valid && op_legal) begin
                        op_d = bus_io.op_code;
                    end else if (bus_io.load_valid) begin
                        reg_b_d = bus_io.data_in;
                    end
                end
                StExec: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        result_d       = bus_io.au_result;
                        result_valid_d = 1'b1;
                        state_d        = StDone;
                        // Subtract underflow is flagged; the wrapped result is kept.
                        if ((op_q == OpSub) && (reg_a_q < reg_b_q)) begin
                            error_d = 1'b1;
                        end
                    end
                end
                StDone: begin
`ifdef RESULT_CHAIN_EN
                    if (bus_io.op_valid && op_legal) begin
                        // Implicit ack: the low byte of the result becomes operand A.
                        result_valid_d = 1'b0;
                        reg_a_d        = result_q[7:0];
                        op_d           = bus_io.op_code;
                        state_d        = StGotOp;
                        if (result_q[15:8] != 8'd0) begin
                            error_d = 1'b1;
                        end
                    end else if (bus_io.result_ack) begin
                        result_valid_d = 1'b0;
                        state_d        = StIdle;
                    end
`else
                    if (bus_io.result_ack) begin
                        result_valid_d = 1'b0;
                        state_d        = StIdle;
                    end
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            reg_a_q        <= '0;
            reg_b_q        <= '0;
            op_q           <= '0;
            result_q       <= '0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_a_q        <= reg_a_d;
            reg_b_q        <= reg_b_d;
            op_q           <= op_d;
            result_q       <= result_d;
            cnt_q          <= cnt_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
        end
    end

    // The unit holds its output on 00, so the op is only presented while executing.
    assign bus_io.signal       = (state_q == StExec) ? op_q : 2'b00;
    assign bus_io.data_in_a    = reg_a_q;
    assign bus_io.data_in_b    = reg_b_q;
    assign bus_io.result       = result_q;
    assign bus_io.result_valid = result_valid_q;
    assign bus_io.busy         = (state_q == StExec) || (state_q == StDone);
    assign bus_io.error        = error_q;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Control FSM for the calculator's 8-bit arithmetic unit.
- Collects operand A, an operation code and operand B from the input front end, then drives the unit's `signal`, `data_in_a` and `data_in_b` inputs.
- Captures the 16-bit unit result after a programmable settle time and presents it to the display/output stage with a valid/ack handshake.
- Sits between the keypad/input decoder and the arithmetic unit.

Parameters:
- SETTLE_CYCLES, 1, cycles the unit inputs are held stable before the result is captured; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  synchronous abort; returns the block to idle.
- data_in  input  8  operand value.
- load_valid  input  1  strobe: data_in holds an operand this cycle.
- op_code  input  2  01 add, 10 subtract, 11 multiply, 00 illegal.
- op_valid  input  1  strobe: op_code is valid this cycle.
- start  input  1  "equals" strobe.
- au_result  input  16  arithmetic unit data_out.
- signal  output  2  arithmetic unit operation select.
- data_in_a  output  8  arithmetic unit operand A.
- data_in_b  output  8  arithmetic unit operand B.
- result  output  16  captured result.
- result_valid  output  1  result available; held until acknowledged.
- result_ack  input  1  consumer accepts the result.
- busy  output  1  high in EXEC and DONE.
- error  output  1  sticky error flag.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - reg_a, reg_b, op reg, result and settle counter all 0.
  - signal=00, result_valid=0, busy=0, error=0.
- clr=1 (and rst_n=1): same effect as reset, but error is preserved.
- Cycle priority:
  - rst_n > clr > start > op_valid > load_valid.
  - Exactly one strobe is acted on per cycle; lower-priority strobes that cycle are dropped.
  - Strobes not listed for the current state are ignored.
- Output mapping:
  - data_in_a=reg_a and data_in_b=reg_b at all times.
  - signal=op reg only in EXEC; signal=00 in every other state.
  - The unit holds its previous output on 00, so au_result is only sampled in EXEC.
- States:
  - IDLE:
    - load_valid: reg_a<=data_in, error<=0, -> GOT_A.
  - GOT_A:
    - load_valid: reg_a overwritten, stay.
    - op_valid with op_code!=00: latch op, -> GOT_OP.
    - op_valid with op_code==00: error<=1, stay.
  - GOT_OP:
    - op_valid (legal): op overwritten.
    - op_valid with 00: error<=1, op unchanged.
    - load_valid: reg_b<=data_in, -> GOT_B.
  - GOT_B:
    - load_valid: reg_b overwritten.
    - op_valid (legal): op overwritten.
    - start: counter<=SETTLE_CYCLES-1, -> EXEC.
  - start in IDLE, GOT_A or GOT_OP: error<=1, no state change.
  - EXEC:
    - counter!=0: decrement.
    - counter==0: result<=au_result, result_valid<=1, -> DONE.
    - If op==10 and reg_a<reg_b: error<=1 in the same edge (underflow).
  - DONE:
    - result and result_valid held.
    - result_ack: result_valid<=0, -> IDLE. result keeps its value until the next capture.
- Latency:
  - result_valid rises on the SETTLE_CYCLES-th rising edge after the edge that samples start.
  - busy is high from the edge after start until the edge that samples result_ack.
- Arithmetic: result is exactly the unit's 16-bit output, e.g. subtract wraps (3-5 = 16'hFFFE). No saturation.
- clr or rst_n during EXEC or DONE aborts the operation; result_valid drops on that edge.

Optional Feature:
- Macro: RESULT_CHAIN_EN.
- Defined:
  - In DONE, op_valid with a legal op_code acts as an implicit ack.
  - On that edge: result_valid<=0, reg_a<=result[7:0], op latched, -> GOT_OP.
  - If result[15:8]!=0, error<=1 (truncation).
  - This allows chained calculations (A op B op C).
- Not defined: op_valid in DONE is ignored; only result_ack leaves DONE.

Test Plan:
- SETTLE_CYCLES=1; load 25, op 01, load 17, start -> result=16'd42 and result_valid high one edge after start; busy high; error=0; ack -> IDLE, signal=00.
- Load 200, op 11, load 200, start -> result=16'd40000, error=0; with SETTLE_CYCLES=4, result_valid rises on the 4th edge after start.
- Load 3, op 10, load 5, start -> result=16'hFFFE, error=1; next load_valid in IDLE clears error.
- In GOT_A assert op_valid with op_code=00 -> error=1, state stays GOT_A; then op_valid 01 -> GOT_OP. Same-cycle load_valid+op_valid in GOT_OP -> only op updated, reg_b unchanged.
- In EXEC with SETTLE_CYCLES=4, assert clr on the 2nd cycle -> state IDLE, result_valid never rises, reg_a=reg_b=0. rst_n=0 in DONE -> all outputs 0 after one edge.
- RESULT_CHAIN_EN: 10+20 then op_valid 11 in DONE, load 4, start -> result=16'd120. Chaining 255*2 (510) -> reg_a=8'hFE, error=1.
